apb4_master_bridge: RTL and testbench

// APB4 requester (initiator): converts a simple valid/ready command/response interface into APB4

---
 rtl/apb4_master_bridge.sv | 129 ++++++++++++
 tb/tb_apb4_master_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master_bridge.sv
// APB4 requester bridge: valid/ready command/response port to one APB4 completer.
// One transfer in flight; ACCESS phase optionally aborted after TIMEOUT_CYC wait cycles.
module apb4_master_bridge #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // Command port
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  // Response port
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tmo_o,
  // APB4 requester
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    ready_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic [2:0]              prot_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    tmo_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    accept;
  logic                    timeout_hit;

  assign accept = req_valid_i && ready_q && (state_q == IDLE);

  // cnt_q counts completed wait cycles, so the current ACCESS cycle is cnt_q+1.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (32'(cnt_q) == (TIMEOUT_CYC - 32'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Registered so that ready stays low through the reset cycle itself.
      ready_q <= (state_d == IDLE);
      if (accept) begin
        addr_q  <= req_addr_i;
        write_q <= req_write_i;
        wdata_q <= req_wdata_i;
        strb_q  <= req_write_i ? req_strb_i : '0;
        prot_q  <= req_prot_i;
        cnt_q   <= '0;
      end
      if (state_q == ACCESS) begin
        if (pready_i) begin
          rdata_q <= write_q ? '0 : prdata_i;
          err_q   <= pslverr_i;
          tmo_q   <= 1'b0;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          tmo_q   <= 1'b1;
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign rsp_tmo_o   = tmo_q;

  assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o = (state_q == ACCESS);
  assign paddr_o   = addr_q;
  assign pwrite_o  = write_q;
  assign pwdata_o  = wdata_q;
  assign pstrb_o   = strb_q;
  assign pprot_o   = prot_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Scoreboard bench for apb4_master_bridge: random commands against a transaction-level model,
// with a scripted APB completer and a decoupled response monitor.
module tb_apb4_master_bridge;

  localparam int TMO = 6;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;   // wait states before pready; >= TMO means pready never comes
    logic [31:0] prdata;
    logic        slverr;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   hold_rsp = 1'b0;
  cmd_t plan_q[$];
  exp_t exp_q[$];

  apb4_master_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .req_strb_i (req_strb),
    .req_prot_i (req_prot),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .rsp_tmo_o  (rsp_tmo),
    .paddr_o    (paddr),
    .pprot_o    (pprot),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .pwdata_o   (pwdata),
    .pstrb_o    (pstrb),
    .pready_i   (pready),
    .prdata_i   (prdata),
    .pslverr_i  (pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Transaction-level expectation: what the requester must report for a given completer script.
  function automatic exp_t model(input cmd_t c, input int acc);
    exp_t e;
    bit   to;
    to        = (c.waits >= TMO);
    e.tmo     = to;
    e.err     = to ? 1'b1 : c.slverr;
    e.rdata   = (to || c.write) ? 32'h0 : c.prdata;
    e.lat     = to ? TMO + 2 : c.waits + 3;
    e.acc_cyc = acc;
    return e;
  endfunction

  function automatic cmd_t mk(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                              input logic [3:0] strb, input int waits, input logic [31:0] rd,
                              input logic slverr);
    cmd_t c;
    c.addr = addr; c.write = write; c.wdata = wdata; c.strb = strb;
    c.prot = 3'($urandom_range(0, 7)); c.waits = waits; c.prdata = rd; c.slverr = slverr;
    return c;
  endfunction

  task automatic issue(input cmd_t c);
    int n = 0;
    req_valid = 1'b1; req_addr = c.addr; req_write = c.write;
    req_wdata = c.wdata; req_strb = c.strb; req_prot = c.prot;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_wait", 64'(req_ready), 64'(1));
      req_valid = 1'b0;
      return;
    end
    plan_q.push_back(c);
    exp_q.push_back(model(c, cyc));
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_write = 1'($urandom_range(0, 1)); req_strb = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Response ready with random backpressure unless held off.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = !hold_rsp && ($urandom_range(0, 3) != 0);
    end
  end

  // APB completer: follows the per-transfer script and checks the requester's bus signals.
  initial begin
    cmd_t cur;
    int   remaining = 0;
    int   acc_n = 0;
    bit   in_xfer = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_xfer = 1'b0;
        pready  = 1'b0;
        continue;
      end
      pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      if (psel && !penable) begin
        if (plan_q.size() == 0) begin
          check("unexpected_setup", 64'(plan_q.size()), 64'(1));
          in_xfer = 1'b0;
        end else begin
          cur = plan_q.pop_front();
          check("setup_paddr", 64'(paddr), 64'(cur.addr));
          check("setup_pwrite", 64'(pwrite), 64'(cur.write));
          check("setup_pstrb", 64'(pstrb), 64'(cur.write ? cur.strb : 4'h0));
          check("setup_pprot", 64'(pprot), 64'(cur.prot));
          if (cur.write) check("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
          remaining = cur.waits;
          acc_n     = 0;
          in_xfer   = 1'b1;
        end
      end else if (psel && penable && in_xfer) begin
        acc_n++;
        if (cur.waits >= TMO) begin
          pready = 1'b0;
        end else if (remaining == 0) begin
          pready = 1'b1; prdata = cur.prdata; pslverr = cur.slverr;
          check("access_paddr_hold", 64'(paddr), 64'(cur.addr));
          if (cur.write) check("access_pwdata_hold", 64'(pwdata), 64'(cur.wdata));
        end else begin
          pready = 1'b0;
          remaining--;
        end
      end else if (in_xfer && !psel) begin
        check("access_cycles", 64'(acc_n), 64'((cur.waits >= TMO) ? TMO : cur.waits + 1));
        check("penable_low", 64'(penable), 64'(0));
        in_xfer = 1'b0;
      end
    end
  end

  // Response monitor: latency on first presentation, payload on handshake.
  initial begin
    exp_t e;
    bit   seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          e = exp_q[0];
          if (!seen) begin
            check("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
            seen = 1'b1;
          end
          if (rsp_ready) begin
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("rsp_tmo", 64'(rsp_tmo), 64'(e.tmo));
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    cmd_t c;
    exp_t ea;
    int   n;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_psel", 64'(psel), 64'(0));
    check("reset_penable", 64'(penable), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_paddr", 64'(paddr), 64'(0));
    check("reset_pwdata", 64'(pwdata), 64'(0));
    check("reset_pstrb", 64'(pstrb), 64'(0));
    check("reset_pprot", 64'(pprot), 64'(0));
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;

    // Directed: zero-wait write, 5 wait states (pready on the last allowed cycle), slave error,
    // and a completer that never answers.
    issue(mk(32'h8, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0));
    issue(mk(32'h4, 1'b0, 32'h0, 4'hF, TMO - 1, 32'h1234_5678, 1'b0));
    issue(mk(32'hC, 1'b0, 32'h0, 4'h3, 0, 32'hCAFE_F00D, 1'b1));
    issue(mk(32'h40, 1'b0, 32'h0, 4'h0, TMO, 32'h5555_AAAA, 1'b0));
    drain();

    // Response backpressure with a competing command waiting.
    hold_rsp = 1'b1;
    c  = mk(32'h10, 1'b0, 32'h0, 4'h0, 1, 32'hA5A5_0F0F, 1'b0);
    ea = model(c, 0);
    issue(c);
    req_valid = 1'b1; req_addr = 32'hFFF0; req_write = 1'b1; req_wdata = 32'h1111_2222;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 64'(0));
      check("bp_psel", 64'(psel), 64'(0));
      check("bp_rsp_valid_hold", 64'(rsp_valid), 64'(1));
      check("bp_rdata_hold", 64'(rsp_rdata), 64'(ea.rdata));
      check("bp_err_hold", 64'(rsp_err), 64'(ea.err));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hold_rsp  = 1'b0;
    drain();

    // Reset while in ACCESS drops the transfer.
    issue(mk(32'h20, 1'b0, 32'h0, 4'h0, 3, 32'h7777_8888, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(psel && penable) && n < 20);
    check("rst_in_access", 64'(psel && penable), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_psel", 64'(psel), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      int r, w;
      r = $urandom_range(0, 9);
      if (r < 6)       w = $urandom_range(0, 2);
      else if (r < 8)  w = TMO - 1;
      else if (r == 8) w = TMO;
      else             w = $urandom_range(3, TMO - 2);
      issue(mk($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), w,
               $urandom, 1'($urandom_range(0, 1))));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    check("plan_consumed", 64'(plan_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
